argmax_layer: RTL

//   Final classification stage. Sits directly downstream of the last dense_layer.

---
 rtl/argmax_layer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/argmax_layer.sv
// Purpose : final classification stage. Snapshots NUM_INPUTS signed activations on a
//           rising edge of inputs_ready, scans them one per cycle, and reports the
//           index and value of the largest one (lowest index wins ties).
// Latency : start sampled at edge T -> output_ready high after edge T+NUM_INPUTS-1
//           (after edge T when NUM_INPUTS==1).
// Backpressure: none. Start edges arriving during a scan are dropped, not queued.
// Ports   : clock, reset (sync, active-high), inputs_ready (level, rising edge = start),
//           inputs[NUM_INPUTS] (DATA_W-bit signed), class_index, max_value, output_ready.
module argmax_layer #(
  parameter int NUM_INPUTS = 10,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                inputs_ready,
  input  logic [NUM_INPUTS-1:0][DATA_W-1:0]   inputs,
  output logic [IDX_W-1:0]                    class_index,
  output logic signed [DATA_W-1:0]            max_value,
  output logic                                output_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      prev_ready;
  logic                      start;
  logic [DATA_W-1:0]         snapshot [NUM_INPUTS];
  logic signed [DATA_W-1:0]  best;
  logic [IDX_W-1:0]          best_idx;
  logic [IDX_W-1:0]          i;
  logic                      last;
  logic signed [DATA_W-1:0]  cand;
  logic                      cand_wins;

  // FSM outputs driving the datapath
  logic                      load;
  logic                      step;
  logic                      finish;
  logic [IDX_W-1:0]          res_idx;
  logic signed [DATA_W-1:0]  res_val;

  assign start = inputs_ready & ~prev_ready;
  assign last  = (i == LAST_IDX);

  // A single-entry build never scans, so the element under the cursor is always entry 0.
  generate
    if (NUM_INPUTS == 1) begin : g_one
      assign cand = $signed(snapshot[0]);
    end else begin : g_many
      assign cand = $signed(snapshot[i]);
    end
  endgenerate

  assign cand_wins = (state == SCAN) && (cand > best);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (NUM_INPUTS == 1) ? DONE : SCAN;
      SCAN:       if (last)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output logic: control strobes and the result presented on DONE entry
  always_comb begin
    load    = start && (state != SCAN);
    step    = (state == SCAN);
    finish  = (step && last) || (load && (NUM_INPUTS == 1));
    res_idx = cand_wins ? i : best_idx;
    res_val = cand_wins ? cand : best;
    // Single-entry build finishes on the load edge itself, straight from the inputs.
    if (load) begin
      res_idx = '0;
      res_val = $signed(inputs[0]);
    end
  end

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_ready   <= 1'b0;
      best         <= '0;
      best_idx     <= '0;
      i            <= '0;
      class_index  <= '0;
      max_value    <= '0;
      output_ready <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) snapshot[k] <= '0;
    end else begin
      prev_ready <= inputs_ready;

      if (load) begin
        for (int k = 0; k < NUM_INPUTS; k++) snapshot[k] <= inputs[k];
        best     <= $signed(inputs[0]);
        best_idx <= '0;
        i        <= IDX_W'(1);
      end else if (step) begin
        if (cand_wins) begin
          best     <= cand;
          best_idx <= i;
        end
        if (!last) i <= i + 1'b1;
      end

      // finish has priority so a single-entry restart from DONE keeps output_ready high.
      if (finish) begin
        class_index  <= res_idx;
        max_value    <= res_val;
        output_ready <= 1'b1;
      end else if (load) begin
        output_ready <= 1'b0;
      end
    end
  end

endmodule
